// File: rtl/sdr_parameters.sv
// Shared types for the SDR APB master: FSM state encoding, queued command format
// and a debug helper that turns a state into printable ASCII.
package sdr_parameters;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_mst_state_t;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
    } apb_cmd_t;

    // Six ASCII characters, space padded, for waveform or log display.
    function automatic logic [47:0] state_name(input apb_mst_state_t st);
        logic [47:0] name;
        case (st)
            StIdle:   name = "IDLE  ";
            StSetup:  name = "SETUP ";
            StAccess: name = "ACCESS";
            default:  name = "BAD   ";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/sdr_cmd_fifo.sv
// Command FIFO for the APB master with a registered head stage: a pushed entry
// becomes visible at the head one cycle after it is written.
module sdr_cmd_fifo
    import sdr_parameters::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  apb_cmd_t push_data_i,
    output logic     full_o,
    input  logic     pop_i,
    output apb_cmd_t head_o,
    output logic     head_valid_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    apb_cmd_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;
    apb_cmd_t        head_q, head_d;
    logic            head_valid_q, head_valid_d;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PtrW'(push_i);
        rd_ptr_d     = rd_ptr_q + PtrW'(pop_i);
        count_d      = count_q + CntW'(push_i) - CntW'(pop_i);
        full_d       = (count_d == CntW'(Depth));
        // Only entries already stored before this edge may become the head.
        head_valid_d = ((count_q - CntW'(pop_i)) != '0);
        head_d       = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o       = full_q;
    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;

endmodule

// File: rtl/sdr_apb_master.sv
// Queued APB master: host commands go through sdr_cmd_fifo and are issued in order
// as SETUP/ACCESS transfers. Define SDR_APB_TIMEOUT_EN to abort stalled ACCESS phases.
module sdr_apb_master
    import sdr_parameters::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        pselect,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [15:0] pwdata,
    input  logic [15:0] prdata,
    input  logic [15:0] pready
);

    apb_mst_state_t state_q, state_d;
    apb_cmd_t       cmd_q, cmd_d;
    apb_cmd_t       push_cmd;
    apb_cmd_t       head;
    logic           head_valid;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           done;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_rdata_q, rsp_rdata_d;
    logic           unused_pready;

`ifdef SDR_APB_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            rsp_err_q, rsp_err_d;
`else
    logic            unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYC;
`endif

    // Held low during reset so the host cannot push into a FIFO being cleared.
    assign cmd_ready = preset & ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    sdr_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (pclk),
        .rst_ni       (preset),
        .push_i       (push),
        .push_data_i  (push_cmd),
        .full_o       (fifo_full),
        .pop_i        (pop),
        .head_o       (head),
        .head_valid_o (head_valid)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pop         = 1'b0;
        done        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
`ifdef SDR_APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            StIdle:  state_d = StIdle;
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready[0]) begin
                    done        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cmd_q.write ? 16'h0000 : prdata;
`ifdef SDR_APB_TIMEOUT_EN
                end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    done        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Issue from IDLE or straight after a completion, so back-to-back skips IDLE.
        if (state_q == StIdle || done) begin
            if (head_valid) begin
                pop     = 1'b1;
                cmd_d   = head;
                state_d = StSetup;
`ifdef SDR_APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef SDR_APB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign unused_pready = ^pready[15:1];

    assign pselect   = (state_q != StIdle);
    assign penable   = (state_q == StAccess);
    assign pwrite    = cmd_q.write;
    assign paddr     = cmd_q.addr;
    assign pwdata    = cmd_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sdr_apb_master.sv
// Directed bench for sdr_apb_master: single write, waited read, full FIFO with
// back-to-back issue, simultaneous push/pop, reset mid-transfer and (optionally) timeout.
module tb_sdr_apb_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        pselect;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic [15:0] pready;
    logic        prd_fixed_en;
    logic [15:0] prd_fixed;

    int n_vec = 0;
    int n_err = 0;

    sdr_apb_master #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pselect   (pselect),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    // Slave read data: low address byte followed by 0xC3, unless a fixed value is forced.
    assign prdata = prd_fixed_en ? prd_fixed : {paddr[7:0], 8'hC3};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {10'b0, pselect, penable, pwrite, paddr, pwdata,
                rsp_valid, rsp_rdata, rsp_err, cmd_ready};
    endfunction

    task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp_rdata, input logic exp_err,
                            input logic exp_psel);
        int n = 0;
        tick();
        while (rsp_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, exp_err);
        check({tag, "_psel"}, pselect, exp_psel);
    endtask

    initial begin
        preset       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        pready       = '0;
        prd_fixed_en = 1'b0;
        prd_fixed    = '0;

        // Reset state
        #3;
        check("rst_outs", all_outs(), 64'h0);
        tick();
        tick();
        preset = 1'b1;
        #1;
        check("rst_release_ready", cmd_ready, 1);
        check("rst_fifo_count", dut.u_fifo.count_q, 0);

        // Single write, pready high from the start (ignored in IDLE/SETUP)
        pready = 16'h0001;
        push(1'b1, 16'h0010, 16'hA5A5);
        check("w_lat_k", pselect, 0);
        tick();
        check("w_lat_k1", pselect, 0);
        tick();
        check("w_setup", {pselect, penable, pwrite, paddr, pwdata},
              {1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5});
        tick();
        check("w_access", {pselect, penable, pwrite, paddr, pwdata},
              {1'b1, 1'b1, 1'b1, 16'h0010, 16'hA5A5});
        tick();
        check("w_rsp", {pselect, rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b1, 1'b0, 16'h0000});
        tick();
        check("w_rsp_pulse", rsp_valid, 0);

        // Read with three wait cycles
        pready = 16'h0000;
        push(1'b0, 16'h0020, 16'h0000);
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("r_access_hold", {pselect, penable, pwrite, paddr},
                  {1'b1, 1'b1, 1'b0, 16'h0020});
            if (i == 3) begin
                pready       = 16'h0001;
                prd_fixed_en = 1'b1;
                prd_fixed    = 16'h1234;
            end
            tick();
        end
        check("r_rsp", {rsp_valid, rsp_err, rsp_rdata, pselect}, {1'b1, 1'b0, 16'h1234, 1'b0});
        pready       = 16'h0000;
        prd_fixed_en = 1'b0;

        // Fill the FIFO behind a stalled transfer, then drain back-to-back
        tick();
        pready = 16'hFFFE;
        push(1'b0, 16'h0100, 16'h0000);
        tick();
        tick();
        tick();
        check("f_c0_access", {penable, paddr}, {1'b1, 16'h0100});
        push(1'b1, 16'h0104, 16'h2222);
        push(1'b0, 16'h0108, 16'h0000);
        push(1'b1, 16'h010C, 16'h4444);
        push(1'b0, 16'h0110, 16'h0000);
        check("f_full_ready", cmd_ready, 0);
        check("f_full_count", dut.u_fifo.count_q, 4);
        cmd_write = 1'b1;
        cmd_addr  = 16'h0114;
        cmd_wdata = 16'h6666;
        cmd_valid = 1'b1;
        tick();
        check("f_held", {cmd_ready, penable, rsp_valid}, {1'b0, 1'b1, 1'b0});
        check("f_held_count", dut.u_fifo.count_q, 4);
        pready = 16'h0001;
        tick();
        check("f_c0_rsp", {rsp_valid, rsp_rdata, pselect, penable}, {1'b1, 16'h00C3, 1'b1, 1'b0});
        check("f_no_push_when_full", dut.u_fifo.count_q, 3);
        check("f_ready_again", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("f_c5_pushed", dut.u_fifo.count_q, 4);
        wait_rsp("f_c1", 16'h0000, 1'b0, 1'b1);
        wait_rsp("f_c2", 16'h08C3, 1'b0, 1'b1);
        wait_rsp("f_c3", 16'h0000, 1'b0, 1'b1);
        wait_rsp("f_c4", 16'h10C3, 1'b0, 1'b1);
        wait_rsp("f_c5", 16'h0000, 1'b0, 1'b0);

        // Push and pop on the same edge with three queued
        pready = 16'h0000;
        push(1'b0, 16'h0200, 16'h0000);
        push(1'b0, 16'h0204, 16'h0000);
        push(1'b1, 16'h0208, 16'h8888);
        push(1'b0, 16'h020C, 16'h0000);
        check("s_count3", {dut.u_fifo.count_q, penable, paddr}, {3'd3, 1'b1, 16'h0200});
        cmd_write = 1'b0;
        cmd_addr  = 16'h0210;
        cmd_wdata = 16'h0000;
        cmd_valid = 1'b1;
        pready    = 16'h0001;
        tick();
        cmd_valid = 1'b0;
        check("s_count_kept", dut.u_fifo.count_q, 3);
        check("s_d0_rsp", {rsp_valid, rsp_rdata, pselect}, {1'b1, 16'h00C3, 1'b1});
        wait_rsp("s_d1", 16'h04C3, 1'b0, 1'b1);
        wait_rsp("s_d2", 16'h0000, 1'b0, 1'b1);
        wait_rsp("s_d3", 16'h0CC3, 1'b0, 1'b1);
        wait_rsp("s_d4", 16'h10C3, 1'b0, 1'b0);

        // Reset in the middle of ACCESS with two commands queued
        pready = 16'h0000;
        push(1'b1, 16'h0400, 16'hABCD);
        push(1'b1, 16'h0404, 16'h1357);
        push(1'b0, 16'h0408, 16'h0000);
        tick();
        check("x_pre_reset", {penable, pwrite, paddr, dut.u_fifo.count_q},
              {1'b1, 1'b1, 16'h0400, 3'd2});
        preset = 1'b0;
        #1;
        check("x_reset_outs", all_outs(), 64'h0);
        tick();
        tick();
        check("x_reset_hold", all_outs(), 64'h0);
        preset = 1'b1;
        #1;
        check("x_release", {cmd_ready, dut.u_fifo.count_q}, {1'b1, 3'd0});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("x_quiet", {pselect, rsp_valid}, 2'b00);
        end

`ifdef SDR_APB_TIMEOUT_EN
        // Stuck slave: abort after eight ACCESS cycles, then the next command issues
        pready = 16'h0000;
        push(1'b0, 16'h0300, 16'h0000);
        push(1'b1, 16'h0304, 16'h7777);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t_access_stall", {penable, rsp_valid, paddr}, {1'b1, 1'b0, 16'h0300});
            tick();
        end
        check("t_abort_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 16'h0000});
        check("t_next_setup", {pselect, penable, paddr}, {1'b1, 1'b0, 16'h0304});
        pready = 16'h0001;
        wait_rsp("t_next_done", 16'h0000, 1'b0, 1'b0);
        pready = 16'h0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
